// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: shift-add multiply, restoring divide, then sign fix-up.
// Latency: done pulses 33 cycles after start is accepted; start is ignored while busy, flush aborts.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [XLEN-1:0]     src_a,
  input  logic [XLEN-1:0]     src_b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [2*XLEN-1:0]   prod,
  output logic                div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q;
  logic [XLEN-1:0]     a_raw_q;
  logic                is_div_q, neg_res_q, neg_a_q, b_zero_q;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN-1:0]     mul_addend;
  logic [XLEN:0]       mul_sum, div_hi;
  logic                div_ge;
  logic [XLEN-1:0]     quo_fix, rem_fix;
  logic [2*XLEN-1:0]   fix_res;
  logic                accept;

  assign accept = (state_q == IDLE) && start && !flush;
  assign busy   = (state_q != IDLE);

  // Magnitudes are only taken for the signed ops (op[0] == 0).
  assign a_neg = ~op[0] & src_a[XLEN-1];
  assign b_neg = ~op[0] & src_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !flush) state_d = CALC;
      CALC: begin
        if (flush)                                 state_d = IDLE;
        else if (cnt_q == CNT_W'(XLEN-1))          state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: multiply shifts the accumulator right, divide shifts {rem, quo} left.
  always_comb begin
    mul_addend = acc_q[0] ? opnd_q : {XLEN{1'b0}};
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    div_hi     = acc_q[2*XLEN-1:XLEN-1];
    div_ge     = (div_hi >= {1'b0, opnd_q});
    if (is_div_q)
      acc_d = {(div_ge ? XLEN'(div_hi - {1'b0, opnd_q}) : div_hi[XLEN-1:0]),
               acc_q[XLEN-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_comb begin
    quo_fix = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!is_div_q)
      fix_res = neg_res_q ? -acc_q : acc_q;
    else if (b_zero_q)
      fix_res = {a_raw_q, {XLEN{1'b1}}};
    else
      fix_res = {rem_fix, quo_fix};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      a_raw_q     <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_a_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      done        <= 1'b0;
      prod        <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt_q       <= '0;
        is_div_q    <= op[1];
        neg_res_q   <= a_neg ^ b_neg;
        neg_a_q     <= a_neg;
        b_zero_q    <= (src_b == {XLEN{1'b0}});
        a_raw_q     <= src_a;
        opnd_q      <= op[1] ? b_mag : a_mag;
        acc_q       <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
        div_by_zero <= 1'b0;
      end else if (state_q == CALC && !flush) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIX && !flush) begin
        prod        <= fix_res;
        done        <= 1'b1;
        div_by_zero <= is_div_q & b_zero_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy, done, div_by_zero;
  logic [63:0] prod;

  typedef struct {
    logic [63:0] p;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
    .done(done), .prod(prod), .div_by_zero(div_by_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Reference: plain signed/unsigned arithmetic; truncating division.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b, output logic dz);
    longint sa, sbv;
    int     ia, ib, q, r;
    logic [63:0] res;
    dz = 1'b0;
    res = '0;
    case (o)
      2'd0: begin sa = $signed(a); sbv = $signed(b); res = sa * sbv; end
      2'd1: res = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) begin dz = 1'b1; res = {a, 32'hFFFFFFFF}; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
        else begin
          ia = a; ib = b; q = ia / ib; r = ia % ib;
          res = {r, q};
        end
      end
      default: begin
        if (b == 0) begin dz = 1'b1; res = {a, 32'hFFFFFFFF}; end
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Caller must be away from the posedge; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done);
    exp_t e;
    logic dz;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (expect_done) begin
      e.p   = model(o, a, b, dz);
      e.dz  = dz;
      e.cyc = cyc + 33;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: every done must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done cyc=%0d prod=%h", cyc, prod);
        end else begin
          e = sb.pop_front();
          chk("prod", prod, e.p);
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  logic [63:0] prev;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    issue(2'd0, 32'hFFFFFFFD, 32'h5, 1);        wait_drain(40);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait_drain(40);
    issue(2'd2, 32'hFFFFFFF9, 32'h2, 1);        wait_drain(40);
    issue(2'd3, 32'd100, 32'd7, 1);             wait_drain(40);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1); wait_drain(40);
    issue(2'd3, 32'd5, 32'd0, 1);               wait_drain(40);
    issue(2'd2, 32'hFFFFFFF0, 32'd0, 1);        wait_drain(40);

    // start while busy is ignored
    issue(2'd0, 32'd1234, 32'hFFFFFF00, 1);
    repeat (4) @(negedge clock);
    op = 2'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_held", 64'(busy), 64'd1);
    wait_drain(40);
    repeat (40) @(negedge clock);

    // back-to-back: new start during the done cycle
    issue(2'd0, 32'd77, 32'hFFFFFFFE, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) break;
    end
    issue(2'd1, 32'd3, 32'd4, 1);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_drain(40);

    // flush mid-divide
    prev = prod;
    @(negedge clock);
    issue(2'd2, 32'd1000, 32'd3, 0);
    repeat (19) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    chk("flush_prod", prod, prev);

    // start together with flush in IDLE is ignored
    flush = 1'b1;
    issue(2'd1, 32'd2, 32'd2, 0);
    flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'd0);
    @(negedge clock);
    issue(2'd3, 32'd1000, 32'd3, 1);            wait_drain(40);

    // asynchronous reset mid-CALC
    @(negedge clock);
    issue(2'd1, 32'd7, 32'd9, 0);
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_prod", prod, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("arst_no_done_busy", 64'(busy), 64'd0);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clock);
      @(negedge clock);
      issue(ro, ra, rb, 1);
      wait_drain(40);
    end

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
